// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge: turns Z80 CPU bus cycles into single handshaked downstream
// transfers. The CPU pins are decoded on the rising CLK edge. The CPU is held
// with nWAIT until bus_ack arrives, and read data is then driven back to it.
// Optional feature macro: BUS_BRIDGE_TIMEOUT_EN. When it is defined, a transfer
// that gets no ack within TIMEOUT_CYCLES cycles completes with 8'hFF and a
// one-cycle bus_err pulse.
module z80_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  d_from_cpu,
  output logic [7:0]  d_to_cpu,
  output logic        d_to_cpu_oe,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  output logic        nWAIT,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic        bus_inta,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        nwait_q, nwait_d;
  logic        oe_q, oe_d;
  logic        err_q, err_d;
  logic [7:0]  dout_q, dout_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic        inta_q, inta_d;
  logic        rd_q, rd_d;

  logic mem_rd, mem_wr, io_rd, io_wr, inta, any_term;
  logic tmo;

  // Cycle-type decode. The pins feed the state flops directly, so each decode
  // result is only acted on at the rising edge. Refresh cycles are masked out.
  always_comb begin
    mem_rd   = !nMREQ && !nRD && nRFSH;
    mem_wr   = !nMREQ && !nWR && nRFSH;
    io_rd    = !nIORQ && !nRD && nM1;
    io_wr    = !nIORQ && !nWR && nM1;
    inta     = !nIORQ && !nM1;
    any_term = mem_rd || mem_wr || io_rd || io_wr || inta;
  end

`ifdef BUS_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Count REQ cycles without an ack. tmo fires on the last allowed cycle.
  always_comb begin
    tmo   = (state_q == REQ) && !bus_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    cnt_d = '0;
    if (state_q == REQ && !bus_ack && !tmo) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register. It is cleared in every state other than REQ.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  // With no timeout, REQ waits for ack indefinitely. The parameter has no effect in this build.
  assign tmo = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Next-state logic and transfer latching. Outputs are derived from the next state so they come out registered.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    io_d    = io_q;
    inta_d  = inta_q;
    rd_d    = rd_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (any_term) begin
        state_d = REQ;
        addr_d  = A;
        wdata_d = d_from_cpu;
        if (inta || io_rd || io_wr) begin
          // I/O space takes priority: INTA, then I/O read, then I/O write.
          io_d   = 1'b1;
          inta_d = inta;
          rd_d   = inta || io_rd;
          we_d   = !inta && !io_rd && io_wr;
        end else begin
          io_d   = 1'b0;
          inta_d = 1'b0;
          rd_d   = mem_rd;
          we_d   = !mem_rd;
        end
      end
      REQ: if (bus_ack) begin
        state_d = DONE;
        if (rd_q) dout_d = bus_rdata;
      end else if (tmo) begin
        state_d = DONE;
        dout_d  = 8'hFF;
        err_d   = 1'b1;
      end
      DONE: if (!any_term) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bus_req_d = (state_d == REQ);
    nwait_d   = (state_d != REQ);
    oe_d      = (state_d == DONE) && rd_d;
  end

  // State and registered outputs. Reset drops any transfer in progress immediately.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      bus_req_q <= 1'b0;
      nwait_q   <= 1'b1;
      oe_q      <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= 8'h00;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      inta_q    <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= bus_req_d;
      nwait_q   <= nwait_d;
      oe_q      <= oe_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      io_q      <= io_d;
      inta_q    <= inta_d;
      rd_q      <= rd_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign nWAIT       = nwait_q;
  assign d_to_cpu_oe = oe_q;
  assign d_to_cpu    = dout_q;
  assign bus_err     = err_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_we      = we_q;
  assign bus_io      = io_q;
  assign bus_inta    = inta_q;

endmodule
